// File: rtl/dmem_pkg.sv
// Shared types and store-formatting helpers for the MEM-stage data memory sequencer.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Request fields frozen on IDLE->REQ so the bus stays stable during the handshake.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  funct3;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_req_t;

   // Size is funct3[1:0]; any 1x encoding behaves as a word access.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = a[0];
         default: is_misaligned = |a;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   store_be = 4'b0001 << a;
         2'b01:   store_be = 4'b0011 << a;
         default: store_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'b00:   store_wdata = {4{d[7:0]}};
         2'b01:   store_wdata = {2{d[15:0]}};
         default: store_wdata = d;
      endcase
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_align.sv
// Shifts the read word down to the addressed byte lane and sign/zero-extends it.
module load_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [31:0] shifted;

   assign shifted = rdata >> {addr_lo, 3'b000};

   always_comb begin
      data = shifted;
      case (funct3)
         F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   data = {24'h0, shifted[7:0]};
         F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   data = {16'h0, shifted[15:0]};
         F3_W:    data = shifted;
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory sequencer: req/ready handshake with timeout, pipeline stall,
// store byte-lane formatting and load alignment.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead_mem_i,
   input  logic        MemWrite_mem_i,
   input  logic [2:0]  funct3_mem_i,
   input  logic [31:0] addr_mem_i,
   input  logic [31:0] store_data_mem_i,
   input  logic        hold_i,
   output logic        stall_o,
   output logic [31:0] load_data_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   mem_req_t           req_q;
   logic               req_r;
   logic               err_r;
   logic [31:0]        ld_r;
   logic [31:0]        aligned;
   logic [1:0]         sz;
   logic               want, misaligned, access;

   assign sz         = funct3_mem_i[1:0];
   assign want       = MemRead_mem_i | MemWrite_mem_i;
   assign misaligned = want & is_misaligned(sz, addr_mem_i[1:0]);
   assign access     = want & ~misaligned;

   // Gated by rst so every output reads zero while reset is applied.
   assign stall_o    = ~rst & (((state == IDLE) & access) | (state == REQ));
   assign misalign_o = ~rst & (state == IDLE) & misaligned;

   assign mem_req_o   = req_r;
   assign mem_we_o    = req_q.we;
   assign mem_addr_o  = {req_q.addr[31:2], 2'b00};
   assign mem_be_o    = req_q.be;
   assign mem_wdata_o = req_q.wdata;
   assign bus_err_o   = err_r;
   assign load_data_o = ld_r;

   load_align u_load_align (
      .funct3  (req_q.funct3),
      .addr_lo (req_q.addr[1:0]),
      .rdata   (mem_rdata_i),
      .data    (aligned)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         req_q <= '0;
         req_r <= 1'b0;
         err_r <= 1'b0;
         ld_r  <= '0;
      end else begin
         err_r <= 1'b0;
         case (state)
            IDLE: if (access && !hold_i) begin
               state        <= REQ;
               req_r        <= 1'b1;
               req_q.we     <= MemWrite_mem_i;
               req_q.addr   <= addr_mem_i;
               req_q.funct3 <= funct3_mem_i;
               req_q.be     <= MemWrite_mem_i ? store_be(sz, addr_mem_i[1:0]) : 4'b1111;
               req_q.wdata  <= MemWrite_mem_i ? store_wdata(sz, store_data_mem_i) : '0;
            end
            REQ: if (mem_ready_i) begin
               state <= DONE;
               req_r <= 1'b0;
               if (!req_q.we) ld_r <= aligned;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state <= DONE;
               req_r <= 1'b0;
               err_r <= 1'b1;
               ld_r  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
            // Held in DONE while the pipeline is frozen so the access never reissues.
            DONE: if (!hold_i) begin
               state <= IDLE;
               cnt   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
